axil_register_slice: RTL and testbench

//  Timing-isolation stage between an AXI-Lite master and an AXI-Lite slave
//  (e.g. CPU bus port -> peripheral). Each of the five channels (AW, W, B, AR, R) gets an

---
 rtl/axil_pkg.sv | 20 ++
 rtl/axil_skid_buffer.sv | 102 ++++++++++
 rtl/axil_register_slice.sv | 157 +++++++++++++++
 tb/tb_axil_register_slice.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// ---------------------------------------------------------------------------
// axil_pkg
//   Shared AXI-Lite definitions for the register slice and its skid buffers.
//   Contents:
//     RESP_OKAY / RESP_SLVERR  - response encodings carried on B and R
//     axil_prot_t              - 3-bit protection field on AW and AR
//     AXIL_RESP_WIDTH          - width of the response field
//     AXIL_PROT_WIDTH          - width of the protection field
// ---------------------------------------------------------------------------
package axil_pkg;

  localparam int AXIL_RESP_WIDTH = 2;
  localparam int AXIL_PROT_WIDTH = 3;

  localparam logic [AXIL_RESP_WIDTH-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXIL_RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;

  typedef logic [AXIL_PROT_WIDTH-1:0] axil_prot_t;

endpackage : axil_pkg

// File: rtl/axil_skid_buffer.sv
// ---------------------------------------------------------------------------
// axil_skid_buffer
//   One valid/ready channel stage. With ENABLE=1 it is a two-entry skid
//   buffer (output register + skid register) that registers valid, payload
//   and ready, while sustaining one beat per cycle. With ENABLE=0 every
//   signal is a plain wire and the block holds no state.
//
//   Ports:
//     clk_i        in   1      clock, rising edge
//     rst_ni       in   1      asynchronous, active-low reset
//     in_data_i    in   WIDTH  upstream payload
//     in_valid_i   in   1      upstream valid
//     in_ready_o   out  1      upstream ready (registered when ENABLE=1)
//     out_data_o   out  WIDTH  downstream payload
//     out_valid_o  out  1      downstream valid
//     out_ready_i  in   1      downstream ready
// ---------------------------------------------------------------------------
module axil_skid_buffer #(
  parameter int WIDTH  = 8,
  parameter bit ENABLE = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  if (ENABLE) begin : g_reg

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             ready_q;
    logic             accept;

    // A beat enters only when we advertised ready in the previous cycle.
    assign accept = in_valid_i && ready_q;

    // Next-state selection. While the skid entry is occupied ready_q is 0,
    // so draining the skid entry and accepting a new beat never coincide.
    always_comb begin
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      skid_data_d  = skid_data_q;
      skid_valid_d = skid_valid_q;

      if (skid_valid_q) begin
        if (out_ready_i) begin
          out_data_d   = skid_data_q;
          out_valid_d  = 1'b1;
          skid_valid_d = 1'b0;
        end
      end else if (accept) begin
        if (!out_valid_q || out_ready_i) begin
          out_data_d  = in_data_i;
          out_valid_d = 1'b1;
        end else begin
          skid_data_d  = in_data_i;
          skid_valid_d = 1'b1;
        end
      end else if (out_ready_i) begin
        out_valid_d = 1'b0;
      end
    end

    // Ready is derived from the next skid state and registered, so there is
    // no combinational path from out_ready_i to in_ready_o. It sits at 0 in
    // reset and rises on the first edge after release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        out_data_q   <= '0;
        skid_data_q  <= '0;
        out_valid_q  <= 1'b0;
        skid_valid_q <= 1'b0;
        ready_q      <= 1'b0;
      end else begin
        out_data_q   <= out_data_d;
        skid_data_q  <= skid_data_d;
        out_valid_q  <= out_valid_d;
        skid_valid_q <= skid_valid_d;
        ready_q      <= !skid_valid_d;
      end
    end

    assign in_ready_o  = ready_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;

  end else begin : g_pass

    assign in_ready_o  = out_ready_i;
    assign out_data_o  = in_data_i;
    assign out_valid_o = in_valid_i;

  end

endmodule : axil_skid_buffer

// File: rtl/axil_register_slice.sv
// ---------------------------------------------------------------------------
// axil_register_slice
//   Timing-isolation stage between an AXI-Lite master (s_axil_* side) and an
//   AXI-Lite slave (m_axil_* side). Each of the five channels has its own
//   independent skid buffer that can be built as registered or as a
//   pass-through. Beats are never reordered, dropped or duplicated, and no
//   AW/W pairing or B/R ordering is imposed here.
//
//   Ports:
//     aclk, aresetn                        clock, async active-low reset
//     s_axil_aw* / s_axil_w* / s_axil_ar*  request channels from the master
//     s_axil_b*  / s_axil_r*               response channels to the master
//     m_axil_aw* / m_axil_w* / m_axil_ar*  request channels to the slave
//     m_axil_b*  / m_axil_r*               response channels from the slave
//
//   Payload packing per channel:
//     AW {awaddr,awprot}  W {wdata,wstrb}  B {bresp}
//     AR {araddr,arprot}  R {rdata,rresp}
// ---------------------------------------------------------------------------
module axil_register_slice
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int AW_REG     = 1,
  parameter int W_REG      = 1,
  parameter int B_REG      = 1,
  parameter int AR_REG     = 1,
  parameter int R_REG      = 1
) (
  input  logic                       aclk,
  input  logic                       aresetn,

  // Upstream (master-facing) side
  input  logic [ADDR_WIDTH-1:0]      s_axil_awaddr,
  input  axil_prot_t                 s_axil_awprot,
  input  logic                       s_axil_awvalid,
  output logic                       s_axil_awready,
  input  logic [DATA_WIDTH-1:0]      s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]      s_axil_wstrb,
  input  logic                       s_axil_wvalid,
  output logic                       s_axil_wready,
  output logic [AXIL_RESP_WIDTH-1:0] s_axil_bresp,
  output logic                       s_axil_bvalid,
  input  logic                       s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]      s_axil_araddr,
  input  axil_prot_t                 s_axil_arprot,
  input  logic                       s_axil_arvalid,
  output logic                       s_axil_arready,
  output logic [DATA_WIDTH-1:0]      s_axil_rdata,
  output logic [AXIL_RESP_WIDTH-1:0] s_axil_rresp,
  output logic                       s_axil_rvalid,
  input  logic                       s_axil_rready,

  // Downstream (slave-facing) side
  output logic [ADDR_WIDTH-1:0]      m_axil_awaddr,
  output axil_prot_t                 m_axil_awprot,
  output logic                       m_axil_awvalid,
  input  logic                       m_axil_awready,
  output logic [DATA_WIDTH-1:0]      m_axil_wdata,
  output logic [STRB_WIDTH-1:0]      m_axil_wstrb,
  output logic                       m_axil_wvalid,
  input  logic                       m_axil_wready,
  input  logic [AXIL_RESP_WIDTH-1:0] m_axil_bresp,
  input  logic                       m_axil_bvalid,
  output logic                       m_axil_bready,
  output logic [ADDR_WIDTH-1:0]      m_axil_araddr,
  output axil_prot_t                 m_axil_arprot,
  output logic                       m_axil_arvalid,
  input  logic                       m_axil_arready,
  input  logic [DATA_WIDTH-1:0]      m_axil_rdata,
  input  logic [AXIL_RESP_WIDTH-1:0] m_axil_rresp,
  input  logic                       m_axil_rvalid,
  output logic                       m_axil_rready
);

  localparam int AX_W = ADDR_WIDTH + AXIL_PROT_WIDTH;
  localparam int W_W  = DATA_WIDTH + STRB_WIDTH;
  localparam int B_W  = AXIL_RESP_WIDTH;
  localparam int R_W  = DATA_WIDTH + AXIL_RESP_WIDTH;

  logic [AX_W-1:0] aw_in, aw_out;
  logic [W_W-1:0]  w_in,  w_out;
  logic [B_W-1:0]  b_in,  b_out;
  logic [AX_W-1:0] ar_in, ar_out;
  logic [R_W-1:0]  r_in,  r_out;

  assign aw_in = {s_axil_awaddr, s_axil_awprot};
  assign w_in  = {s_axil_wdata, s_axil_wstrb};
  assign ar_in = {s_axil_araddr, s_axil_arprot};
  // Response channels flow from the slave back to the master.
  assign b_in  = m_axil_bresp;
  assign r_in  = {m_axil_rdata, m_axil_rresp};

  assign {m_axil_awaddr, m_axil_awprot} = aw_out;
  assign {m_axil_wdata,  m_axil_wstrb}  = w_out;
  assign {m_axil_araddr, m_axil_arprot} = ar_out;
  assign s_axil_bresp                   = b_out;
  assign {s_axil_rdata,  s_axil_rresp}  = r_out;

  axil_skid_buffer #(.WIDTH(AX_W), .ENABLE(AW_REG != 0)) u_aw (
    .clk_i       (aclk),
    .rst_ni      (aresetn),
    .in_data_i   (aw_in),
    .in_valid_i  (s_axil_awvalid),
    .in_ready_o  (s_axil_awready),
    .out_data_o  (aw_out),
    .out_valid_o (m_axil_awvalid),
    .out_ready_i (m_axil_awready)
  );

  axil_skid_buffer #(.WIDTH(W_W), .ENABLE(W_REG != 0)) u_w (
    .clk_i       (aclk),
    .rst_ni      (aresetn),
    .in_data_i   (w_in),
    .in_valid_i  (s_axil_wvalid),
    .in_ready_o  (s_axil_wready),
    .out_data_o  (w_out),
    .out_valid_o (m_axil_wvalid),
    .out_ready_i (m_axil_wready)
  );

  axil_skid_buffer #(.WIDTH(B_W), .ENABLE(B_REG != 0)) u_b (
    .clk_i       (aclk),
    .rst_ni      (aresetn),
    .in_data_i   (b_in),
    .in_valid_i  (m_axil_bvalid),
    .in_ready_o  (m_axil_bready),
    .out_data_o  (b_out),
    .out_valid_o (s_axil_bvalid),
    .out_ready_i (s_axil_bready)
  );

  axil_skid_buffer #(.WIDTH(AX_W), .ENABLE(AR_REG != 0)) u_ar (
    .clk_i       (aclk),
    .rst_ni      (aresetn),
    .in_data_i   (ar_in),
    .in_valid_i  (s_axil_arvalid),
    .in_ready_o  (s_axil_arready),
    .out_data_o  (ar_out),
    .out_valid_o (m_axil_arvalid),
    .out_ready_i (m_axil_arready)
  );

  axil_skid_buffer #(.WIDTH(R_W), .ENABLE(R_REG != 0)) u_r (
    .clk_i       (aclk),
    .rst_ni      (aresetn),
    .in_data_i   (r_in),
    .in_valid_i  (m_axil_rvalid),
    .in_ready_o  (m_axil_rready),
    .out_data_o  (r_out),
    .out_valid_o (s_axil_rvalid),
    .out_ready_i (s_axil_rready)
  );

endmodule : axil_register_slice

// File: tb/tb_axil_register_slice.sv
// ---------------------------------------------------------------------------
// tb_axil_register_slice
//   Directed bench for the AXI-Lite register slice. The main instance has
//   every channel registered; a second instance built with AW_REG=0 shares
//   the same inputs and is used to look at the pass-through AW channel.
// ---------------------------------------------------------------------------
module tb_axil_register_slice;
  import axil_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          aclk    = 1'b0;
  logic          aresetn = 1'b0;

  logic [AW-1:0] s_axil_awaddr  = '0;
  axil_prot_t    s_axil_awprot  = '0;
  logic          s_axil_awvalid = 1'b0;
  logic [DW-1:0] s_axil_wdata   = '0;
  logic [SW-1:0] s_axil_wstrb   = '0;
  logic          s_axil_wvalid  = 1'b0;
  logic          s_axil_bready  = 1'b0;
  logic [AW-1:0] s_axil_araddr  = '0;
  axil_prot_t    s_axil_arprot  = '0;
  logic          s_axil_arvalid = 1'b0;
  logic          s_axil_rready  = 1'b0;
  logic          m_axil_awready = 1'b1;
  logic          m_axil_wready  = 1'b1;
  logic [1:0]    m_axil_bresp   = '0;
  logic          m_axil_bvalid  = 1'b0;
  logic          m_axil_arready = 1'b1;
  logic [DW-1:0] m_axil_rdata   = '0;
  logic [1:0]    m_axil_rresp   = '0;
  logic          m_axil_rvalid  = 1'b0;

  logic          s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
  logic [1:0]    s_axil_bresp, s_axil_rresp;
  logic [DW-1:0] s_axil_rdata;
  logic [AW-1:0] m_axil_awaddr, m_axil_araddr;
  axil_prot_t    m_axil_awprot, m_axil_arprot;
  logic          m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready;
  logic [DW-1:0] m_axil_wdata;
  logic [SW-1:0] m_axil_wstrb;

  logic          pt_s_awready, pt_s_wready, pt_s_bvalid, pt_s_arready, pt_s_rvalid;
  logic [1:0]    pt_s_bresp, pt_s_rresp;
  logic [DW-1:0] pt_s_rdata;
  logic [AW-1:0] pt_m_awaddr, pt_m_araddr;
  axil_prot_t    pt_m_awprot, pt_m_arprot;
  logic          pt_m_awvalid, pt_m_wvalid, pt_m_arvalid, pt_m_bready, pt_m_rready;
  logic [DW-1:0] pt_m_wdata;
  logic [SW-1:0] pt_m_wstrb;

  int compared   = 0;
  int mismatched = 0;

  // Free-running 100 MHz clock.
  always #5 aclk = ~aclk;

  axil_register_slice dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  axil_register_slice #(.AW_REG(0)) dut_pt (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(pt_s_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(pt_s_wready),
    .s_axil_bresp(pt_s_bresp), .s_axil_bvalid(pt_s_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(pt_s_arready),
    .s_axil_rdata(pt_s_rdata), .s_axil_rresp(pt_s_rresp),
    .s_axil_rvalid(pt_s_rvalid), .s_axil_rready(s_axil_rready),
    .m_axil_awaddr(pt_m_awaddr), .m_axil_awprot(pt_m_awprot),
    .m_axil_awvalid(pt_m_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(pt_m_wdata), .m_axil_wstrb(pt_m_wstrb),
    .m_axil_wvalid(pt_m_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(pt_m_bready),
    .m_axil_araddr(pt_m_araddr), .m_axil_arprot(pt_m_arprot),
    .m_axil_arvalid(pt_m_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(pt_m_rready)
  );

  // Readies must be low in reset and rise one edge after release.
  task automatic test_reset();
    @(negedge aclk);
    @(negedge aclk);
    compared++;
    if ({s_axil_awready, s_axil_wready, s_axil_arready, m_axil_bready, m_axil_rready} !== 5'b00000) begin
      mismatched++;
      $display("[TB] FAIL reset_ready_low: got %b expected 00000",
               {s_axil_awready, s_axil_wready, s_axil_arready, m_axil_bready, m_axil_rready});
    end
    compared++;
    if ({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, s_axil_bvalid, s_axil_rvalid} !== 5'b00000) begin
      mismatched++;
      $display("[TB] FAIL reset_valid_low: got %b expected 00000",
               {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, s_axil_bvalid, s_axil_rvalid});
    end
    aresetn = 1'b1;
    #1;
    compared++;
    if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL release_before_edge: got %b expected 000",
               {s_axil_awready, s_axil_wready, s_axil_arready});
    end
    @(negedge aclk);
    compared++;
    if ({s_axil_awready, s_axil_wready, s_axil_arready, m_axil_bready, m_axil_rready} !== 5'b11111) begin
      mismatched++;
      $display("[TB] FAIL release_ready_high: got %b expected 11111",
               {s_axil_awready, s_axil_wready, s_axil_arready, m_axil_bready, m_axil_rready});
    end
    compared++;
    if ({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL release_valid_low: got %b expected 000",
               {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid});
    end
  endtask

  // Eight AW beats in consecutive cycles must come out in consecutive cycles.
  task automatic test_aw_back_to_back();
    m_axil_awready = 1'b1;
    @(negedge aclk);
    for (int k = 0; k <= 9; k++) begin
      if (k >= 1 && k <= 8) begin
        compared++;
        if (m_axil_awvalid !== 1'b1 || m_axil_awaddr !== 32'((k - 1) * 4) ||
            m_axil_awprot !== 3'(k - 1)) begin
          mismatched++;
          $display("[TB] FAIL aw_beat%0d: got v=%b addr=%h prot=%h expected v=1 addr=%h prot=%h",
                   k - 1, m_axil_awvalid, m_axil_awaddr, m_axil_awprot, 32'((k - 1) * 4), 3'(k - 1));
        end
      end
      if (k == 9) begin
        compared++;
        if (m_axil_awvalid !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL aw_drain: got v=%b expected 0", m_axil_awvalid);
        end
      end
      if (k < 8) begin
        compared++;
        if (s_axil_awready !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL aw_ready%0d: got %b expected 1", k, s_axil_awready);
        end
        s_axil_awvalid = 1'b1;
        s_axil_awaddr  = 32'(k * 4);
        s_axil_awprot  = 3'(k);
      end else begin
        s_axil_awvalid = 1'b0;
      end
      if (k < 9) @(negedge aclk);
    end
  endtask

  // Two W beats against a stalled slave fill both entries, then drain in order.
  task automatic test_w_skid();
    m_axil_wready = 1'b0;
    @(negedge aclk);
    s_axil_wvalid = 1'b1;
    s_axil_wdata  = 32'hA5A5_A5A5;
    s_axil_wstrb  = 4'hF;
    @(negedge aclk);
    compared++;
    if (m_axil_wvalid !== 1'b1 || m_axil_wdata !== 32'hA5A5_A5A5 || m_axil_wstrb !== 4'hF) begin
      mismatched++;
      $display("[TB] FAIL w_first_out: got v=%b data=%h strb=%h expected v=1 data=a5a5a5a5 strb=f",
               m_axil_wvalid, m_axil_wdata, m_axil_wstrb);
    end
    s_axil_wdata = 32'h1234_5678;
    s_axil_wstrb = 4'h3;
    @(negedge aclk);
    compared++;
    if (s_axil_wready !== 1'b0 || m_axil_wdata !== 32'hA5A5_A5A5) begin
      mismatched++;
      $display("[TB] FAIL w_full: got ready=%b data=%h expected ready=0 data=a5a5a5a5",
               s_axil_wready, m_axil_wdata);
    end
    s_axil_wvalid = 1'b0;
    m_axil_wready = 1'b1;
    @(negedge aclk);
    compared++;
    if (m_axil_wvalid !== 1'b1 || m_axil_wdata !== 32'h1234_5678 || m_axil_wstrb !== 4'h3 ||
        s_axil_wready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL w_second_out: got v=%b data=%h strb=%h ready=%b expected v=1 data=12345678 strb=3 ready=1",
               m_axil_wvalid, m_axil_wdata, m_axil_wstrb, s_axil_wready);
    end
    @(negedge aclk);
    compared++;
    if (m_axil_wvalid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL w_drain: got v=%b expected 0", m_axil_wvalid);
    end
  endtask

  // A single B response from the slave reaches the master one cycle later.
  task automatic test_b_path();
    s_axil_bready = 1'b1;
    @(negedge aclk);
    m_axil_bvalid = 1'b1;
    m_axil_bresp  = RESP_SLVERR;
    @(negedge aclk);
    m_axil_bvalid = 1'b0;
    m_axil_bresp  = RESP_OKAY;
    compared++;
    if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== RESP_SLVERR) begin
      mismatched++;
      $display("[TB] FAIL b_out: got v=%b resp=%b expected v=1 resp=10", s_axil_bvalid, s_axil_bresp);
    end
    @(negedge aclk);
    compared++;
    if (s_axil_bvalid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b_drain: got v=%b expected 0", s_axil_bvalid);
    end
  endtask

  // Random valid/ready on R: every beat must arrive once, in order, and the
  // payload must hold while stalled.
  task automatic test_r_random();
    logic [DW+1:0] sb[$];
    logic [DW+1:0] exp_beat;
    int            sent = 0;
    int            got = 0;
    int            cycles = 0;
    logic          in_hs = 1'b0;
    logic          hold_chk = 1'b0;
    logic [DW+1:0] hold_beat = '0;
    m_axil_rvalid = 1'b0;
    s_axil_rready = 1'b0;
    while (got < 1000 && cycles < 20000) begin
      @(negedge aclk);
      cycles++;
      if (hold_chk) begin
        compared++;
        if (s_axil_rvalid !== 1'b1 || {s_axil_rdata, s_axil_rresp} !== hold_beat) begin
          mismatched++;
          $display("[TB] FAIL r_stable: got v=%b beat=%h expected v=1 beat=%h",
                   s_axil_rvalid, {s_axil_rdata, s_axil_rresp}, hold_beat);
        end
      end
      if (in_hs || !m_axil_rvalid) begin
        if (sent < 1000 && $urandom_range(0, 1) == 1) begin
          m_axil_rvalid = 1'b1;
          m_axil_rdata  = $urandom;
          m_axil_rresp  = 2'($urandom_range(0, 3));
        end else begin
          m_axil_rvalid = 1'b0;
        end
      end
      s_axil_rready = 1'($urandom_range(0, 1));
      in_hs = m_axil_rvalid && m_axil_rready;
      if (in_hs) begin
        sb.push_back({m_axil_rdata, m_axil_rresp});
        sent++;
      end
      if (s_axil_rvalid && s_axil_rready) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL r_order: got beat=%h expected no beat", {s_axil_rdata, s_axil_rresp});
        end else begin
          exp_beat = sb.pop_front();
          if ({s_axil_rdata, s_axil_rresp} !== exp_beat) begin
            mismatched++;
            $display("[TB] FAIL r_order: beat %0d got %h expected %h",
                     got, {s_axil_rdata, s_axil_rresp}, exp_beat);
          end
        end
        got++;
      end
      hold_chk  = s_axil_rvalid && !s_axil_rready;
      hold_beat = {s_axil_rdata, s_axil_rresp};
    end
    compared++;
    if (got != 1000) begin
      mismatched++;
      $display("[TB] FAIL r_timeout: got %0d beats expected 1000", got);
    end
    m_axil_rvalid = 1'b0;
    s_axil_rready = 1'b1;
  endtask

  // Reset with both AR entries occupied clears valid asynchronously and
  // nothing stale comes out afterwards.
  task automatic test_ar_reset();
    m_axil_arready = 1'b0;
    @(negedge aclk);
    s_axil_arvalid = 1'b1;
    s_axil_araddr  = 32'h0000_0100;
    @(negedge aclk);
    s_axil_araddr  = 32'h0000_0104;
    @(negedge aclk);
    s_axil_arvalid = 1'b0;
    compared++;
    if (m_axil_arvalid !== 1'b1 || m_axil_araddr !== 32'h0000_0100 || s_axil_arready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ar_full: got v=%b addr=%h ready=%b expected v=1 addr=00000100 ready=0",
               m_axil_arvalid, m_axil_araddr, s_axil_arready);
    end
    #2;
    aresetn = 1'b0;
    #1;
    compared++;
    if (m_axil_arvalid !== 1'b0 || m_axil_araddr !== 32'h0 || s_axil_arready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ar_async_reset: got v=%b addr=%h ready=%b expected v=0 addr=00000000 ready=0",
               m_axil_arvalid, m_axil_araddr, s_axil_arready);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    m_axil_arready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      compared++;
      if (m_axil_arvalid !== 1'b0 || s_axil_arready !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL ar_no_stale%0d: got v=%b ready=%b expected v=0 ready=1",
                 k, m_axil_arvalid, s_axil_arready);
      end
    end
    s_axil_arvalid = 1'b1;
    s_axil_araddr  = 32'h0000_0200;
    s_axil_arprot  = 3'h5;
    @(negedge aclk);
    s_axil_arvalid = 1'b0;
    compared++;
    if (m_axil_arvalid !== 1'b1 || m_axil_araddr !== 32'h0000_0200 || m_axil_arprot !== 3'h5) begin
      mismatched++;
      $display("[TB] FAIL ar_after_reset: got v=%b addr=%h prot=%h expected v=1 addr=00000200 prot=5",
               m_axil_arvalid, m_axil_araddr, m_axil_arprot);
    end
    @(negedge aclk);
  endtask

  // Pass-through AW: valid, payload and ready all follow within the cycle.
  task automatic test_aw_passthrough();
    m_axil_awready = 1'b0;
    @(negedge aclk);
    s_axil_awvalid = 1'b1;
    s_axil_awaddr  = 32'hDEAD_BEE0;
    s_axil_awprot  = 3'h2;
    #1;
    compared++;
    if (pt_m_awvalid !== 1'b1 || pt_m_awaddr !== 32'hDEAD_BEE0 || pt_m_awprot !== 3'h2 ||
        pt_s_awready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL pt_aw_valid: got v=%b addr=%h prot=%h ready=%b expected v=1 addr=deadbee0 prot=2 ready=0",
               pt_m_awvalid, pt_m_awaddr, pt_m_awprot, pt_s_awready);
    end
    m_axil_awready = 1'b1;
    #1;
    compared++;
    if (pt_s_awready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL pt_aw_ready: got %b expected 1", pt_s_awready);
    end
    s_axil_awvalid = 1'b0;
    #1;
    compared++;
    if (pt_m_awvalid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL pt_aw_drop: got v=%b expected 0", pt_m_awvalid);
    end
    repeat (3) @(negedge aclk);
  endtask

  initial begin
    $display("[TB] starting axil_register_slice bench");
    test_reset();
    test_aw_back_to_back();
    test_w_skid();
    test_b_path();
    test_r_random();
    test_ar_reset();
    test_aw_passthrough();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_axil_register_slice
